// File: rtl/antares_pkg.sv
// Shared definitions for the Antares fetch stage.
// Contents: fetch FSM state encoding, NOP instruction word, PC increment
// and the default reset PC.
package antares_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_DISCARD = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry hold buffer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : kill the IF/ID entry and clear the hold buffer
//   load           : write in_instr/in_pc straight into IF/ID
//   capture        : write in_instr/in_pc into the hold buffer
//   promote        : move the hold buffer into IF/ID
//   consume        : decode takes the current entry (clears valid)
//   in_instr/in_pc : incoming instruction and its address
//   valid/instr/pc/pc4 : IF/ID contents
module if_id_reg
  import antares_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              load,
  input  logic              capture,
  input  logic              promote,
  input  logic              consume,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_INSTR);

  logic [DATA_W-1:0] hold_instr;
  logic [ADDR_W-1:0] hold_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      instr      <= NOP;
      pc         <= '0;
      pc4        <= '0;
      hold_instr <= NOP;
      hold_pc    <= '0;
    end else if (flush) begin
      // Flush beats a same-cycle consume or load: the entry simply dies.
      valid      <= 1'b0;
      hold_instr <= NOP;
      hold_pc    <= '0;
    end else begin
      if (capture) begin
        hold_instr <= in_instr;
        hold_pc    <= in_pc;
      end
      if (load) begin
        valid <= 1'b1;
        instr <= in_instr;
        pc    <= in_pc;
        pc4   <= in_pc + INC;   // wraps modulo 2^ADDR_W
      end else if (promote) begin
        valid <= 1'b1;
        instr <= hold_instr;
        pc    <= hold_pc;
        pc4   <= hold_pc + INC;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Antares instruction fetch stage.
// Takes nextPC from the PC controller, fetches from instruction memory with
// a req/ack transaction and loads the IF/ID register.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   nextPC, flush         : next fetch address / redirect strobe
//   id_stall              : decode cannot take IF/ID this cycle
//   fetch_stall           : nextPC not consumed this cycle (hold it)
//   imem_req/addr/ack/rdata : instruction memory port
//   if_valid/instr/pc/pc4 : IF/ID register contents
//   dbg_state             : current fetch FSM state
//
// Memory handshake: imem_req is the valid side and imem_ack the one-shot
// ready/response. Once imem_req is high, imem_req and imem_addr hold until
// the cycle imem_ack is seen; a request is never withdrawn, even by a flush.
// Decode handshake: if_valid is valid, !id_stall is ready; an entry transfers
// on an edge where both are high.
module fetch_unit
  import antares_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] nextPC,
  input  logic              flush,
  input  logic              id_stall,
  output logic              fetch_stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output fetch_state_t      dbg_state
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fa_q, fa_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              load, capture, promote, consume, id_accept;

  assign id_accept = !if_valid || !id_stall;
  assign consume   = if_valid && !id_stall;
  assign dbg_state = state_q;
  assign imem_addr = addr_q;

  always_comb begin
    state_d     = state_q;
    fa_d        = fa_q;
    fetch_stall = 1'b1;
    imem_req    = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    promote     = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (id_accept) begin
            load        = 1'b1;
            fetch_stall = 1'b0;
            fa_d        = nextPC;
          end else begin
            capture = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // IF/ID is necessarily valid here, so ID accepts exactly when !id_stall.
        if (!id_stall) begin
          promote     = 1'b1;
          fetch_stall = 1'b0;
          fa_d        = nextPC;
          state_d     = ST_REQ;
        end
      end
      ST_DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      fetch_stall = 1'b0;
      fa_d        = nextPC;
      load        = 1'b0;
      capture     = 1'b0;
      promote     = 1'b0;
      // An un-acked request on the bus cannot be cancelled: wait it out.
      if ((state_q == ST_REQ || state_q == ST_DISCARD) && !imem_ack)
        state_d = ST_DISCARD;
      else
        state_d = ST_REQ;
    end
  end

  // The bus address follows fa, except while an abandoned request is still
  // outstanding: then it must keep showing the old address until the ack.
  assign addr_d = (state_d == ST_DISCARD) ? addr_q : {fa_d[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fa_q    <= RESET_PC;
      addr_q  <= {RESET_PC[ADDR_W-1:2], 2'b00};
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      addr_q  <= addr_d;
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .load     (load),
    .capture  (capture),
    .promote  (promote),
    .consume  (consume),
    .in_instr (imem_rdata),
    .in_pc    (fa_q),
    .valid    (if_valid),
    .instr    (if_instr),
    .pc       (if_pc),
    .pc4      (if_pc4)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the Antares pipelined MIPS-style processor. Consumes the next-PC value from the PC controller, runs a request/acknowledge transaction with instruction memory, and loads the IF/ID pipeline register. Back-pressures the PC controller through `fetch_stall` whenever it cannot accept a new address: a multi-cycle memory, a stalled decode stage, or an un-cancellable in-flight request after a flush.

## Interface
Parameters:
- `ADDR_W`, 32, address / PC width
- `DATA_W`, 32, instruction width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `nextPC`  in  ADDR_W  next address from PC controller; sampled only when `fetch_stall`=0 or `flush`=1
- `flush`  in  1  branch/jump redirect; `nextPC` holds the redirect target this cycle
- `id_stall`  in  1  decode stage cannot consume IF/ID this cycle
- `fetch_stall`  out  1  to PC controller `stall`: `nextPC` not consumed, hold it
- `imem_req`  out  1  memory request
- `imem_addr`  out  ADDR_W  word-aligned request address
- `imem_ack`  in  1  one-cycle acknowledge; `imem_rdata` valid the same cycle
- `imem_rdata`  in  DATA_W  instruction word
- `if_valid`  out  1  IF/ID holds a live instruction
- `if_instr`  out  DATA_W  IF/ID instruction
- `if_pc`  out  ADDR_W  address of `if_instr`
- `if_pc4`  out  ADDR_W  `if_pc`+4

## Operation
- Internal fetch-address register `fa`, reset to `RESET_PC`. `imem_addr` = {`fa`[31:2], 2'b00}. `if_pc` carries the full `fa`.
- Memory protocol: once `imem_req` rises, `imem_req` and `imem_addr` stay stable until the `imem_ack` cycle. A request is never withdrawn.
- ID accepts when `!if_valid || !id_stall`. An IF/ID entry is consumed at the edge where `if_valid`=1 and `id_stall`=0.
- States:
  - IDLE: `imem_req`=0, `fetch_stall`=1. Next state is REQ. Entered only from reset.
  - REQ: `imem_req`=1.
    - Ack, ID accepts: load IF/ID (`if_valid`=1, instr, pc=`fa`, pc4=`fa`+4). `fetch_stall`=0, `fa`<=`nextPC`, stay in REQ.
    - Ack, ID blocked: capture into the hold buffer, `fetch_stall`=1, go to HOLD.
    - No ack: `fetch_stall`=1.
  - HOLD: `imem_req`=0, `fetch_stall`=1 while `id_stall`=1. When ID accepts: buffer moves to IF/ID, `fetch_stall`=0, `fa`<=`nextPC`, go to REQ.
  - DISCARD: `imem_req`=1 with the old address. Wait for ack and drop the data, `fetch_stall`=1. On ack, go to REQ with the current `fa`.
- Flush (overrides everything except reset):
  - `fa`<=`nextPC`; `if_valid`<=0; hold buffer cleared; `fetch_stall`=0 (target consumed).
  - REQ without ack goes to DISCARD. REQ with ack drops the data and stays in REQ. HOLD/IDLE go to REQ. DISCARD stays in DISCARD.
- Flush wins over a same-cycle ID consume: the stalled entry is killed.
- Arithmetic: `if_pc4` = `fa`+4 modulo 2^ADDR_W, so `fa`=32'hFFFF_FFFC gives `if_pc4`=0.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_stall`=1, `if_valid`=0, `if_instr`=0 (NOP), `if_pc`=0, `if_pc4`=0. State is IDLE.
- First request: cycle 1 after reset deasserts, address `RESET_PC`.
- With zero-wait memory (ack in the req cycle), throughput is 1 instruction/cycle. `if_valid` rises the edge after the ack.
- N-wait memory: `fetch_stall`=1 for N cycles per fetch.
- Flush-to-target request: the next cycle in REQ, or after the outstanding ack in DISCARD.
- Reset mid-operation abandons any in-flight transaction; memory shares the same reset.
- Outputs are registered except `fetch_stall` and `imem_req`, which decode state, `imem_ack`, `flush` and `id_stall` combinationally.

## Structure
- Shared package `antares_pkg`: fetch state encoding (IDLE/REQ/HOLD/DISCARD), `NOP_INSTR`=32'h0, `PC_INC`=4, `RESET_PC` default.
- Sub-module `if_id_reg`: IF/ID register with valid bit, hold buffer, load/consume/flush controls.
- The FSM and `fa` live in `fetch_unit`.

## Test plan
- Reset, then zero-wait memory, `nextPC` stepping 0,4,8 -> `imem_addr` 0,4,8 on consecutive cycles; `if_pc` 0,4,8 with `if_valid`=1 from cycle 2; `fetch_stall`=0 in each ack cycle.
- 2-wait memory at `fa`=0x40 -> `fetch_stall`=1 for 2 cycles, `imem_addr` stable at 0x40; `if_pc4`=0x44 after the ack.
- `id_stall`=1 for 3 cycles while ack arrives -> state HOLD, `imem_req`=0, IF/ID unchanged. On release, the buffered instruction appears in IF/ID the next edge.
- `flush` with target 0x100 during an un-acked request at 0x20 -> `imem_req` stays at 0x20 until ack, data dropped; next request at 0x100; `if_valid`=0 throughout.
- Flush coinciding with the ack -> acked data dropped; next `imem_addr`=target; `if_valid`=0 next cycle.
- `fa`=0xFFFF_FFFC fetched -> `if_pc4`=0. Reset asserted mid-REQ -> all outputs return to reset values the next edge.
